// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   sub_state_e : control FSM states (IDLE, RUN)
//   cnt_width() : bit-counter width needed to count 0..width-1
// ---------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_state_e;

  // Counter width for a bit index in 0..width-1; never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    if (width <= 2) return 1;
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// Single-bit combinational subtractor cell: d = a - b - bin.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow ripples in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor, diff = a - b - bin, LSB first,
// one bit per clock using a single reused full_subtractor cell.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request a new subtraction (sampled only while idle)
//   a, b  : minuend / subtrahend, latched on accepted start
//   bin   : borrow-in, latched on accepted start
//   busy  : high while a subtraction is in progress
//   done  : one-cycle pulse when diff/bout are valid
//   diff  : result (mod 2^WIDTH), valid from done until the next start
//   bout  : final borrow-out
//   ovf   : signed overflow (only when SERIAL_SUBTRACTOR_OVF_EN is defined)
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
// ---------------------------------------------------------------------------
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_d;
  logic bit_bout;

  // The operand shift registers present the current bit at position 0.
  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so that after WIDTH shifts the first
        // (LSB) bit has reached position 0.
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = bit_bout;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bout_d  = bit_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // On the MSB step br_q is the borrow into the MSB.
          ovf_d   = br_q ^ bit_bout;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- A single full-subtractor cell is reused across WIDTH cycles, with a registered borrow between bits.
- It is the inverse-operation counterpart to the team's ripple-carry adder datapath, for area-constrained arithmetic paths that tolerate multi-cycle latency.
- Start/done handshake toward the controlling logic.

Parameters:
WIDTH, 8, operand and result width in bits (min 2).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous reset, active-low.
start  input  1  request a new subtraction; sampled only while idle.
a  input  WIDTH  minuend; latched on accepted start.
b  input  WIDTH  subtrahend; latched on accepted start.
bin  input  1  borrow-in; latched on accepted start.
busy  output  1  high while a subtraction is in progress.
done  output  1  one-cycle pulse when diff/bout become valid.
diff  output  WIDTH  result a - b - bin (mod 2^WIDTH).
bout  output  1  final borrow-out (1 when a < b + bin, unsigned).

Behaviour:
- Reset (async assert, sync release): busy=0, done=0, diff=0, bout=0, bit counter=0, operand shift registers=0, FSM=IDLE.
- FSM states: IDLE, RUN.
- Start acceptance, IDLE: start=1 at edge E0 latches a, b and bin.
  - The borrow register loads bin; counter=0; FSM goes to RUN; busy=1.
- Start while busy is ignored; latched operands and timing are not disturbed.
- Per-bit step, each RUN edge:
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into diff from the MSB side; operands shift right; counter increments.
- Bits are processed at edges E1..E_WIDTH.
- At edge E_WIDTH:
  - diff holds the full result and bout = final borrow.
  - FSM returns to IDLE; busy=0; done=1 for exactly one cycle.
- Latency: WIDTH cycles from accepted start to done.
- diff/bout hold their value until the next accepted start.
  - diff is a working register during RUN and is not valid while busy=1.
- Back-to-back: start=1 in the cycle done=1 is accepted (FSM is IDLE).
  - The next operation begins and the previous diff/bout are overwritten progressively.
  - The consumer must capture results on done.
- Reset mid-operation: immediate return to reset values; no done pulse; the operation is discarded.
- Counter is clog2(WIDTH) bits wide; the terminal count is WIDTH-1, with no wrap beyond it.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), updated together with bout at done.
  - Signed overflow = borrow into MSB XOR borrow out of MSB, i.e. (a_msb != b_msb) && (diff_msb != a_msb), with bin included.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (arith_pkg): FSM state enum (IDLE, RUN) and a width-derived counter-size helper constant function.
- One natural sub-module: full_subtractor (combinational a, b, bin -> d, bout), instantiated once.
  - It mirrors the adder's per-bit cell, so the cell is reusable by future ripple subtractors.

Test Plan:
- Basic: a=0x50, b=0x20, bin=0 -> done exactly 8 cycles after start; diff=0x30, bout=0; busy high for 8 cycles.
- Underflow: a=0x20, b=0x50, bin=0 -> diff=0xD0, bout=1.
- Borrow-in edge: a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; and a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- Handshake:
  - Pulse start again 3 cycles into an operation -> ignored; result of the first op is unchanged.
  - Start asserted in the done cycle -> second op accepted; its done follows 8 cycles later.
- Reset mid-op: assert rst_n=0 at cycle 4 of RUN -> busy/done/diff/bout = 0 immediately; no done after release.
- With SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x05, b=0x03 -> ovf=0.
